// File: rtl/config_regbank.sv
// Multi-page configuration/status register bank shared by SPI, RS232 bridge and processor.
// One rw-page commit per cycle (proc > SPI hold > SPI direct > RS232); proc page written in parallel.
module config_regbank #(
  parameter int unsigned PAGE_BYTES = 128,
  parameter int unsigned RW_PAGES   = 1,
  parameter int unsigned STAT_BYTES = 32,
  parameter int unsigned PROC_BYTES = 8
) (
  input  logic                               clk,
  input  logic                               rst_b,
  input  logic [RW_PAGES*PAGE_BYTES*8-1:0]   cfg_default,
  output logic [RW_PAGES*PAGE_BYTES*8-1:0]   cfg_out,
  output logic [RW_PAGES*PAGE_BYTES-1:0]     cfg_chg,
  input  logic [STAT_BYTES*8-1:0]            stat_in,
  output logic [PROC_BYTES*8-1:0]            proc_page_out,
  input  logic                               spi_wr,
  input  logic                               spi_rd,
  input  logic [11:0]                        spi_adr,
  input  logic [7:0]                         spi_dout,
  output logic [7:0]                         spi_din,
  input  logic [7:0]                         rs232_mem_page,
  input  logic [7:0]                         rs232_mem_offset,
  input  logic                               rs232_mem_wr_en,
  input  logic                               rs232_mem_rd_en,
  input  logic [7:0]                         rs232_mem_wr_data,
  input  logic [7:0]                         rs232_mem_wr_msk,
  output logic [7:0]                         rs232_mem_rd_data,
  output logic                               rs232_mem_ack,
  input  logic                               proc_rd_word_en,
  input  logic                               proc_wr_word_en,
  input  logic [13:0]                        proc_rd_word_addr,
  input  logic [13:0]                        proc_wr_word_addr,
  input  logic [3:0]                         proc_wr_byte_indx,
  input  logic [31:0]                        proc_wr_word_data,
  output logic [31:0]                        proc_rd_word_data,
  output logic [7:0]                         wr_drop_cnt
);

  localparam int unsigned NB = RW_PAGES * PAGE_BYTES;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned SW = (STAT_BYTES > 1) ? $clog2(STAT_BYTES) : 1;
  localparam int unsigned PW = (PROC_BYTES > 1) ? $clog2(PROC_BYTES) : 1;

  logic [NB-1:0][7:0]         cfg_q;
  logic [NB-1:0]              chg_q;
  logic [STAT_BYTES-1:0][7:0] stat_arr;
  logic [STAT_BYTES-1:0][7:0] shadow_q;
  logic [PROC_BYTES-1:0][7:0] proc_q;

  logic        pw_vld_q;
  logic [13:0] pw_addr_q;
  logic [31:0] pw_data_q;
  logic [3:0]  pw_be_q;

  logic          hold_vld_q, pend_vld_q;
  logic [IW-1:0] hold_idx_q, pend_idx_q;
  logic [7:0]    hold_data_q, pend_data_q, pend_msk_q;
  logic          ack_q;
  logic [7:0]    rs_rd_q, drop_q;
  logic [31:0]   prd_q;

  assign stat_arr      = stat_in;
  assign cfg_out       = cfg_q;
  assign cfg_chg       = chg_q;
  assign proc_page_out = proc_q;
  assign rs232_mem_ack     = ack_q;
  assign rs232_mem_rd_data = rs_rd_q;
  assign proc_rd_word_data = prd_q;
  assign wr_drop_cnt       = drop_q;

  function automatic logic rw_hit(input logic [7:0] page, input logic [7:0] off);
    return ((page == 8'd0) || ((page >= 8'd2) && (32'(page) <= RW_PAGES)))
           && (32'(off) < PAGE_BYTES);
  endfunction

  function automatic logic [IW-1:0] rw_index(input logic [7:0] page, input logic [7:0] off);
    int unsigned k;
    k = (page == 8'd0) ? 0 : 32'(page) - 1;
    return IW'(k * PAGE_BYTES + 32'(off));
  endfunction

  // Status offset 0 is always live; other offsets come from the last snapshot.
  function automatic logic [7:0] rd_byte(input logic [7:0] page, input logic [7:0] off);
    logic [7:0] v;
    v = 8'h00;
    if (rw_hit(page, off)) begin
      v = cfg_q[rw_index(page, off)];
    end else if ((page == 8'd1) && (32'(off) < STAT_BYTES)) begin
      v = (off == 8'd0) ? stat_arr[0] : shadow_q[SW'(off)];
    end else if ((page == 8'd4) && (32'(off) < PROC_BYTES)) begin
      v = proc_q[PW'(off)];
    end
    return v;
  endfunction

  // Proc stage lane decode; lane 0 is the lowest byte address and the top data byte.
  logic [7:0]           pw_page, pw_base;
  logic [3:0]           pw_rw_en, pw_proc_en;
  logic [3:0][IW-1:0]   pw_idx;
  logic [3:0][7:0]      pw_byte, pw_off;
  logic                 proc_req;

  always_comb begin
    pw_page = pw_addr_q[13:6];
    pw_base = {pw_addr_q[5:0], 2'b00};
    for (int j = 0; j < 4; j++) begin
      pw_off[j]     = pw_base + 8'(j);
      pw_byte[j]    = pw_data_q[31-8*j -: 8];
      pw_rw_en[j]   = pw_vld_q && pw_be_q[3-j] && rw_hit(pw_page, pw_off[j]);
      pw_idx[j]     = rw_index(pw_page, pw_off[j]);
      pw_proc_en[j] = pw_vld_q && pw_be_q[3-j] && (pw_page == 8'd4)
                      && (32'(pw_off[j]) < PROC_BYTES);
    end
    proc_req = |pw_rw_en;
  end

  logic [7:0]    spi_page, rs_page_rd;
  logic          spi_new, rs_new, rs_nop, rs_req;
  logic [IW-1:0] spi_idx, rs_idx;
  logic [7:0]    rs_data, rs_msk;
  logic          grant_hold, grant_spi, grant_rs, park_spi, drop, snap;

  always_comb begin
    spi_page   = {4'h0, spi_adr[11:8]};
    rs_page_rd = rs232_mem_page;
    spi_new    = spi_wr && rw_hit(spi_page, spi_adr[7:0]);
    spi_idx    = rw_index(spi_page, spi_adr[7:0]);
    rs_new     = rs232_mem_wr_en && rw_hit(rs232_mem_page, rs232_mem_offset);
    rs_nop     = rs232_mem_wr_en && !rs_new;
    rs_req     = pend_vld_q || rs_new;
    rs_idx     = pend_vld_q ? pend_idx_q  : rw_index(rs232_mem_page, rs232_mem_offset);
    rs_data    = pend_vld_q ? pend_data_q : rs232_mem_wr_data;
    rs_msk     = pend_vld_q ? pend_msk_q  : rs232_mem_wr_msk;
    grant_hold = !proc_req && hold_vld_q;
    grant_spi  = !proc_req && !hold_vld_q && spi_new;
    grant_rs   = !proc_req && !hold_vld_q && !spi_new && rs_req;
    park_spi   = spi_new && !grant_spi;
    drop       = park_spi && hold_vld_q && !grant_hold;
    snap       = (spi_rd && (spi_page == 8'd1) && (spi_adr[7:0] == 8'd0))
              || (rs232_mem_rd_en && (rs_page_rd == 8'd1) && (rs232_mem_offset == 8'd0))
              || (proc_rd_word_en && (proc_rd_word_addr == 14'h040));
    spi_din    = rd_byte(spi_page, spi_adr[7:0]);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cfg_q       <= cfg_default;
      chg_q       <= '0;
      shadow_q    <= '0;
      proc_q      <= '0;
      pw_vld_q    <= 1'b0;
      pw_addr_q   <= '0;
      pw_data_q   <= '0;
      pw_be_q     <= '0;
      hold_vld_q  <= 1'b0;
      hold_idx_q  <= '0;
      hold_data_q <= '0;
      pend_vld_q  <= 1'b0;
      pend_idx_q  <= '0;
      pend_data_q <= '0;
      pend_msk_q  <= '0;
      ack_q       <= 1'b0;
      rs_rd_q     <= '0;
      prd_q       <= '0;
      drop_q      <= '0;
    end else begin
      pw_vld_q <= proc_wr_word_en;
      if (proc_wr_word_en) begin
        pw_addr_q <= proc_wr_word_addr;
        pw_data_q <= proc_wr_word_data;
        pw_be_q   <= proc_wr_byte_indx;
      end

      chg_q <= '0;
      if (proc_req) begin
        for (int j = 0; j < 4; j++) begin
          if (pw_rw_en[j]) begin
            cfg_q[pw_idx[j]] <= pw_byte[j];
            chg_q[pw_idx[j]] <= 1'b1;
          end
        end
      end else if (grant_hold) begin
        cfg_q[hold_idx_q] <= hold_data_q;
        chg_q[hold_idx_q] <= 1'b1;
      end else if (grant_spi) begin
        cfg_q[spi_idx] <= spi_dout;
        chg_q[spi_idx] <= 1'b1;
      end else if (grant_rs) begin
        cfg_q[rs_idx] <= (cfg_q[rs_idx] & ~rs_msk) | (rs_data & rs_msk);
        chg_q[rs_idx] <= 1'b1;
      end

      for (int j = 0; j < 4; j++) begin
        if (pw_proc_en[j]) proc_q[PW'(pw_off[j])] <= pw_byte[j];
      end

      // A draining hold register can accept the new loser in the same cycle.
      if (park_spi && (!hold_vld_q || grant_hold)) begin
        hold_vld_q  <= 1'b1;
        hold_idx_q  <= spi_idx;
        hold_data_q <= spi_dout;
      end else if (grant_hold) begin
        hold_vld_q <= 1'b0;
      end
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;

      if (rs_new && !grant_rs) begin
        pend_vld_q  <= 1'b1;
        pend_idx_q  <= rs_idx;
        pend_data_q <= rs232_mem_wr_data;
        pend_msk_q  <= rs232_mem_wr_msk;
      end else if (grant_rs) begin
        pend_vld_q <= 1'b0;
      end

      ack_q <= grant_rs || rs_nop || rs232_mem_rd_en;
      if (rs232_mem_rd_en) rs_rd_q <= rd_byte(rs232_mem_page, rs232_mem_offset);
      if (proc_rd_word_en) begin
        for (int j = 0; j < 4; j++) begin
          prd_q[31-8*j -: 8] <= rd_byte(proc_rd_word_addr[13:6],
                                        {proc_rd_word_addr[5:0], 2'b00} + 8'(j));
        end
      end
      if (snap) shadow_q <= stat_arr;
    end
  end

endmodule

// File: tb/tb_config_regbank.sv
// Scoreboard bench for config_regbank: stimulus pushes cycle-stamped expectations,
// a negedge monitor compares them and pops RS232 acks as they appear.
module tb_config_regbank;
  localparam int unsigned PB = 128;
  localparam int unsigned RP = 3;
  localparam int unsigned SB = 32;
  localparam int unsigned PR = 8;

  localparam int KCfg = 0, KChg = 1, KChgCnt = 2, KDrop = 3, KPpg = 4, KPrd = 5, KSpi = 6;

  logic                  clk = 1'b0;
  logic                  rst_b = 1'b0;
  logic [RP*PB*8-1:0]    cfg_default = '0;
  logic [RP*PB*8-1:0]    cfg_out;
  logic [RP*PB-1:0]      cfg_chg;
  logic [SB*8-1:0]       stat_in = '0;
  logic [PR*8-1:0]       proc_page_out;
  logic                  spi_wr = 0, spi_rd = 0;
  logic [11:0]           spi_adr = '0;
  logic [7:0]            spi_dout = '0, spi_din;
  logic [7:0]            rs_page = '0, rs_off = '0, rs_wdata = '0, rs_msk = '0, rs_rdata;
  logic                  rs_wr = 0, rs_rd = 0, rs_ack;
  logic                  p_rd = 0, p_wr = 0;
  logic [13:0]           p_raddr = '0, p_waddr = '0;
  logic [3:0]            p_be = '0;
  logic [31:0]           p_wdata = '0, p_rdata;
  logic [7:0]            drop_cnt;

  config_regbank #(.PAGE_BYTES(PB), .RW_PAGES(RP), .STAT_BYTES(SB), .PROC_BYTES(PR)) dut (
    .clk(clk), .rst_b(rst_b), .cfg_default(cfg_default), .cfg_out(cfg_out), .cfg_chg(cfg_chg),
    .stat_in(stat_in), .proc_page_out(proc_page_out), .spi_wr(spi_wr), .spi_rd(spi_rd),
    .spi_adr(spi_adr), .spi_dout(spi_dout), .spi_din(spi_din), .rs232_mem_page(rs_page),
    .rs232_mem_offset(rs_off), .rs232_mem_wr_en(rs_wr), .rs232_mem_rd_en(rs_rd),
    .rs232_mem_wr_data(rs_wdata), .rs232_mem_wr_msk(rs_msk), .rs232_mem_rd_data(rs_rdata),
    .rs232_mem_ack(rs_ack), .proc_rd_word_en(p_rd), .proc_wr_word_en(p_wr),
    .proc_rd_word_addr(p_raddr), .proc_wr_word_addr(p_waddr), .proc_wr_byte_indx(p_be),
    .proc_wr_word_data(p_wdata), .proc_rd_word_data(p_rdata), .wr_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] exp;
    int          due;
    string       name;
  } exp_t;

  typedef struct {
    int         due;
    bit         chk_rd;
    logic [7:0] rd;
    string      name;
  } ack_t;

  exp_t sb[$];
  ack_t acks[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   run = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
    spi_wr = 0; spi_rd = 0; rs_wr = 0; rs_rd = 0; p_wr = 0; p_rd = 0;
  endtask

  task automatic expect_at(input int kind, input int idx, input logic [31:0] exp,
                           input int due, input string name);
    exp_t e;
    e.kind = kind; e.idx = idx; e.exp = exp; e.due = due; e.name = name;
    sb.push_back(e);
  endtask

  task automatic expect_ack(input int due, input bit chk, input logic [7:0] rd,
                            input string name);
    ack_t a;
    a.due = due; a.chk_rd = chk; a.rd = rd; a.name = name;
    acks.push_back(a);
  endtask

  task automatic proc_write(input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
    p_wr = 1; p_waddr = a; p_be = be; p_wdata = d;
  endtask

  task automatic spi_write(input logic [11:0] a, input logic [7:0] d);
    spi_wr = 1; spi_adr = a; spi_dout = d;
  endtask

  task automatic rs_write(input logic [7:0] pg, input logic [7:0] off, input logic [7:0] d,
                          input logic [7:0] m);
    rs_wr = 1; rs_page = pg; rs_off = off; rs_wdata = d; rs_msk = m;
  endtask

  task automatic rs_read(input logic [7:0] pg, input logic [7:0] off);
    rs_rd = 1; rs_page = pg; rs_off = off;
  endtask

  always @(negedge clk) begin
    if (run) begin
      int i;
      logic [31:0] act;
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].due == cyc) begin
          case (sb[i].kind)
            KCfg:    act = 32'(cfg_out[8*sb[i].idx +: 8]);
            KChg:    act = 32'(cfg_chg[sb[i].idx]);
            KChgCnt: act = 32'($countones(cfg_chg));
            KDrop:   act = 32'(drop_cnt);
            KPpg:    act = proc_page_out[32*sb[i].idx +: 32];
            KPrd:    act = p_rdata;
            default: act = 32'(spi_din);
          endcase
          checks++;
          if (act !== sb[i].exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", sb[i].name, act,
                     sb[i].exp, cyc);
          end
          sb.delete(i);
        end else begin
          i++;
        end
      end
      if (rs_ack) begin
        checks++;
        if (acks.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ack: got ack expected none (cycle %0d)", cyc);
        end else begin
          ack_t a;
          a = acks.pop_front();
          if (a.due != cyc) begin
            failures++;
            $display("FAIL %s_ack_cycle: got %0d expected %0d", a.name, cyc, a.due);
          end else if (a.chk_rd && (rs_rdata !== a.rd)) begin
            failures++;
            $display("FAIL %s_rdata: got %0h expected %0h", a.name, rs_rdata, a.rd);
          end
        end
      end
    end
  end

  initial begin
    int t;
    cfg_default[8*5 +: 8] = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1;
    run = 1;
    step();

    // Reset state
    t = cyc;
    expect_at(KCfg, 5, 32'hA5, t, "reset_byte5");
    expect_at(KDrop, 0, 32'h0, t, "reset_drop");
    expect_at(KChgCnt, 0, 32'h0, t, "reset_chg");
    expect_at(KPpg, 0, 32'h0, t, "reset_ppg0");
    expect_at(KPpg, 1, 32'h0, t, "reset_ppg1");
    p_rd = 1; p_raddr = 14'h100;
    expect_at(KPrd, 0, 32'h0, t + 1, "reset_proc_rd");
    step(); step();

    // Proc write, byte enables 1010, big-endian lanes
    t = cyc;
    proc_write(14'h001, 4'b1010, 32'h11223344);
    expect_at(KCfg, 4, 32'h00, t + 1, "pw_byte4_early");
    expect_at(KCfg, 4, 32'h11, t + 2, "pw_byte4");
    expect_at(KCfg, 6, 32'h33, t + 2, "pw_byte6");
    expect_at(KCfg, 5, 32'hA5, t + 2, "pw_byte5_kept");
    expect_at(KCfg, 7, 32'h00, t + 2, "pw_byte7_kept");
    expect_at(KChg, 4, 32'h1, t + 2, "pw_chg4");
    expect_at(KChg, 6, 32'h1, t + 2, "pw_chg6");
    expect_at(KChg, 5, 32'h0, t + 2, "pw_chg5");
    expect_at(KChg, 4, 32'h0, t + 3, "pw_chg4_end");
    repeat (4) step();

    // Proc page write and readback; no change strobes
    t = cyc;
    proc_write(14'h100, 4'b1111, 32'hDEADBEEF);
    expect_at(KPpg, 0, 32'hEFBEADDE, t + 2, "ppg_word0");
    expect_at(KChgCnt, 0, 32'h0, t + 2, "ppg_no_chg");
    step(); step();
    p_rd = 1; p_raddr = 14'h100;
    expect_at(KPrd, 0, 32'hDEADBEEF, t + 3, "ppg_proc_rd");
    repeat (4) step();

    // Three sources on byte 0
    t = cyc;
    proc_write(14'h000, 4'b1000, 32'h01000000);
    step();
    spi_write(12'h000, 8'h02);
    rs_write(8'd0, 8'd0, 8'hF0, 8'h0F);
    expect_at(KCfg, 0, 32'h00, t + 1, "arb_b0_t1");
    expect_at(KCfg, 0, 32'h01, t + 2, "arb_b0_proc");
    expect_at(KCfg, 0, 32'h02, t + 3, "arb_b0_spi");
    expect_at(KCfg, 0, 32'h00, t + 4, "arb_b0_rs");
    expect_at(KChg, 0, 32'h1, t + 4, "arb_chg_rs");
    expect_ack(t + 4, 1'b0, 8'h00, "arb_rs");
    repeat (6) step();

    // Proc burst with SPI contention
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      proc_write(14'h003, 4'b1111, 32'h10203040 + 32'(k));
      if (k > 0) spi_write(12'h014, 8'h40 + 8'(k));
      step();
    end
    expect_at(KDrop, 0, 32'd2, t + 5, "burst_drop");
    expect_at(KCfg, 15, 32'h43, t + 5, "burst_last_word");
    expect_at(KCfg, 12, 32'h10, t + 5, "burst_byte12");
    expect_at(KCfg, 20, 32'h00, t + 5, "burst_park_wait");
    expect_at(KCfg, 20, 32'h41, t + 6, "burst_park_commit");
    repeat (5) step();

    // Plain masked RS232 write
    t = cyc;
    rs_write(8'd0, 8'd30, 8'hAB, 8'hFF);
    expect_at(KCfg, 30, 32'hAB, t + 1, "rs_plain");
    expect_ack(t + 1, 1'b0, 8'h00, "rs_plain");
    repeat (3) step();

    // Status snapshot
    stat_in[7:0] = 8'h77;
    stat_in[15:8] = 8'h10;
    t = cyc;
    spi_rd = 1; spi_adr = 12'h100;
    expect_at(KSpi, 0, 32'h77, t, "stat_live0");
    step();
    stat_in[15:8] = 8'h20;
    spi_rd = 1; spi_adr = 12'h101;
    rs_read(8'd1, 8'd1);
    expect_at(KSpi, 0, 32'h10, t + 1, "stat_shadow_spi");
    expect_ack(t + 2, 1'b1, 8'h10, "stat_rs_rd");
    step();
    p_rd = 1; p_raddr = 14'h040;
    expect_at(KPrd, 0, 32'h77100000, t + 3, "stat_proc_rd");
    step();
    spi_adr = 12'h101;
    expect_at(KSpi, 0, 32'h20, t + 3, "stat_resnap");
    repeat (3) step();

    // Upper rw page and unmapped page
    t = cyc;
    spi_write(12'h300, 8'h5A);
    expect_at(KCfg, 256, 32'h5A, t + 1, "pg3_byte256");
    expect_at(KChg, 256, 32'h1, t + 1, "pg3_chg");
    step();
    spi_write(12'h500, 8'hEE);
    expect_at(KSpi, 0, 32'h00, t + 1, "pg5_spi_rd");
    expect_at(KChgCnt, 0, 32'h0, t + 2, "pg5_no_chg");
    expect_at(KCfg, 256, 32'h5A, t + 2, "pg3_kept");
    step();
    rs_read(8'd3, 8'd0);
    expect_ack(t + 3, 1'b1, 8'h5A, "pg3_rs_rd");
    step(); step();
    rs_write(8'd5, 8'd0, 8'hFF, 8'hFF);
    expect_ack(t + 5, 1'b0, 8'h00, "pg5_rs_wr");
    expect_at(KChgCnt, 0, 32'h0, t + 5, "pg5_rs_no_chg");
    step(); step();
    rs_read(8'd5, 8'd0);
    expect_ack(t + 7, 1'b1, 8'h00, "pg5_rs_rd");
    repeat (5) step();

    foreach (sb[i]) begin
      checks++;
      failures++;
      $display("FAIL %s_pending: got none expected check at cycle %0d", sb[i].name, sb[i].due);
    end
    foreach (acks[i]) begin
      checks++;
      failures++;
      $display("FAIL %s_ack_missing: got none expected ack at cycle %0d", acks[i].name,
               acks[i].due);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/config_regbank.md
# config_regbank

Parametrised multi-page configuration/status register bank shared by the SPI slave, the RS232 command bridge and the embedded processor. Holds up to three read/write configuration pages, one snapshot-latched status page and one processor-owned page. Concurrent writes are arbitrated without loss where possible, and every committed configuration byte raises a per-byte change strobe for downstream consumers. Replaces the single-page register memory at the same place in the control path.

## Interface
- PAGE_BYTES, 128: bytes per read/write page; power of two, at most 256.
- RW_PAGES, 1: number of read/write pages, 1..3.
- STAT_BYTES, 32: status page size, at most 256.
- PROC_BYTES, 8: processor page size, multiple of 4.
- clk  in  1  system clock; all logic on the rising edge.
- rst_b  in  1  asynchronous active-low reset.
- cfg_default  in  RW_PAGES*PAGE_BYTES*8  reset image; byte n sits at [8n+7:8n]; rw page k starts at byte k*PAGE_BYTES.
- cfg_out  out  RW_PAGES*PAGE_BYTES*8  current configuration, same packing.
- cfg_chg  out  RW_PAGES*PAGE_BYTES  one-cycle strobe per committed byte.
- stat_in  in  STAT_BYTES*8  live status.
- proc_page_out  out  PROC_BYTES*8  processor page contents.
- spi_wr, spi_rd  in  1  SPI byte strobes.
- spi_adr  in  12  {page[3:0], offset[7:0]}.
- spi_dout  in  8  SPI write data.
- spi_din  out  8  SPI read data; combinational.
- rs232_mem_page, rs232_mem_offset  in  8 each  RS232 byte address.
- rs232_mem_wr_en, rs232_mem_rd_en  in  1  one-cycle RS232 requests.
- rs232_mem_wr_data, rs232_mem_wr_msk  in  8  masked write data and mask.
- rs232_mem_rd_data  out  8  registered RS232 read data.
- rs232_mem_ack  out  1  one-cycle completion pulse.
- proc_rd_word_en, proc_wr_word_en  in  1  processor word strobes.
- proc_rd_word_addr, proc_wr_word_addr  in  14  word address; [13:6] is the page, [5:0] is the word.
- proc_wr_byte_indx  in  4  byte enables; bit 3 selects [31:24] and the lowest byte address.
- proc_wr_word_data  in  32  processor write data; big-endian within the word.
- proc_rd_word_data  out  32  registered processor read data.
- wr_drop_cnt  out  8  saturating count of discarded SPI writes.

## Operation
- Page map:
  - Page 0 is rw page 0.
  - Page 1 is the status page (read-only).
  - Pages 2..RW_PAGES are rw pages 1..RW_PAGES-1.
  - Page 4 is the processor page.
  - Any other page reads 0x00 and ignores writes.
  - Offsets beyond a page's size read 0x00 and ignore writes.
- Processor writes are registered for one stage, which holds address, data and byte enables together. All four byte enables come from that same stage.
- Processor-page writes are processor-only and commit in parallel with rw-page arbitration.
- rw-page write arbitration: one commit per cycle.
  - Priority order: proc stage, then SPI (hold register first, then a direct request), then RS232.
  - A proc commit writes all enabled bytes of the word at once.
- SPI hold register, one entry:
  - A losing SPI write is parked in the hold register.
  - If the hold register is already full, the new SPI write is dropped and wr_drop_cnt increments, saturating at 255.
- RS232 pending register, one entry:
  - A losing RS232 write waits in the pending register.
  - RS232 does not issue a new request before its ack.
  - At commit, the new value is (old & ~msk) | (data & msk), using the byte value at the commit cycle.
- Same byte written by several sources: the last commit wins.
- cfg_chg[n] pulses for one cycle after any commit to byte n, even if the value is unchanged.
- Status snapshot:
  - A read of status offset 0 from any port copies all of stat_in into a shadow in the same cycle.
  - Status reads at offset 0 return live stat_in; reads at other offsets return the shadow.
- Reads are never stalled and do not contend with writes. A read returns the value before any same-cycle commit.

## Timing
- Reset values:
  - cfg_out = cfg_default, sampled while rst_b is low.
  - Processor page, status shadow, both holding registers, cfg_chg, rs232_mem_ack, rs232_mem_rd_data, proc_rd_word_data and wr_drop_cnt are all 0.
- Reset mid-operation discards pending writes with no ack.
- Proc write:
  - Request in cycle T; the stage is valid in T+1, and the commit is visible on cfg_out in T+2.
  - cfg_chg pulses in T+2.
- SPI write with no conflict: issued in T, visible in T+1. Parked: visible one cycle after its grant.
- RS232 write: ack in the cycle after commit; best case T+1.
- RS232 read: data and ack in T+1.
- Proc read: data in T+1; proc_rd_word_data holds its value otherwise.
- spi_din is combinational from spi_adr in the same cycle.

## Test plan
- Reset with cfg_default byte 5 = 0xA5 → cfg_out byte 5 = 0xA5; proc page reads 0; wr_drop_cnt = 0.
- Proc writes addr 0x001, byte enables 0b1010, data 0x11223344 in T → bytes 4 and 6 become 0x11 and 0x33 in T+2; cfg_chg bits 4 and 6 pulse; bytes 5 and 7 unchanged.
- Same cycle: proc write to byte 0 = 0x01, SPI write to byte 0 = 0x02, RS232 write to byte 0 = 0xF0 with mask 0x0F → byte 0 sequence 0x01, 0x02, 0x00; RS232 ack lands one cycle after its commit.
- Four back-to-back proc writes while three SPI writes arrive → first SPI write parked, next two dropped, wr_drop_cnt = 2, parked value committed after the proc burst.
- Read status offset 0 with stat_in byte 1 = 0x10, change it to 0x20, then read offset 1 → returns 0x10.
- RW_PAGES = 3: SPI write to page 3 offset 0 = 0x5A → cfg_out byte 256 = 0x5A; a write to page 5 changes nothing and reads back 0x00.
